jb_pl_sysref_gen: RTL

JB_PL_SYSREF_GEN -- requirements
Module: jb_pl_sysref_gen

---
 rtl/jb_pl_sysref_gen.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/jb_pl_sysref_gen.sv
// Programmable SYSREC/SYSREF pulse generator: continuous or gapped (N periods) operation,
// optionally phase-aligned to a rising edge on an external reference.
module jb_pl_sysref_gen #(
    parameter int unsigned PERIOD_W = 16,
    parameter int unsigned CNT_W    = 8
) (
    input  logic                pl_refclk_i,
    input  logic                pl_rst_i,
    input  logic                start_i,
    input  logic                stop_i,
    input  logic [PERIOD_W-1:0] cfg_period_i,
    input  logic [PERIOD_W-1:0] cfg_high_i,
    input  logic                cfg_mode_i,
    input  logic [CNT_W-1:0]    cfg_npulse_i,
    input  logic                cfg_align_en_i,
    input  logic                align_i,
    output logic                sysref_o,
    output logic                busy_o,
    output logic                done_o,
    output logic                cfg_err_o
);

    typedef enum logic [1:0] {StIdle, StArm, StRun} state_e;

    state_e              state_q, state_d;
    logic [PERIOD_W-1:0] ph_q, ph_d;
    logic [CNT_W-1:0]    pcnt_q, pcnt_d;
    logic [PERIOD_W-1:0] period_q, period_d;
    logic [PERIOD_W-1:0] high_q, high_d;
    logic                mode_q, mode_d;
    logic [CNT_W-1:0]    npulse_q, npulse_d;
    logic                align_en_q, align_en_d;
    logic                stop_q, stop_d;
    logic                done_q, done_d;
    logic                cfg_err_q, cfg_err_d;
    logic                sysref_d;
    (* dont_touch = "true" *) logic sysref_q;
    logic                align_q, align_prev_q;

    logic                cfg_ok;
    logic                align_rise;
    logic                ph_last;
    logic [CNT_W-1:0]    pcnt_inc;

    assign cfg_ok = (cfg_period_i >= PERIOD_W'(2)) &&
                    (cfg_high_i != '0) &&
                    (cfg_high_i < cfg_period_i) &&
                    (!cfg_mode_i || (cfg_npulse_i != '0));

    assign align_rise = align_q & ~align_prev_q;
    assign ph_last    = (ph_q == (period_q - PERIOD_W'(1)));
    assign pcnt_inc   = pcnt_q + CNT_W'(1);

    always_comb begin
        state_d    = state_q;
        ph_d       = ph_q;
        pcnt_d     = pcnt_q;
        period_d   = period_q;
        high_d     = high_q;
        mode_d     = mode_q;
        npulse_d   = npulse_q;
        align_en_d = align_en_q;
        stop_d     = stop_q;
        done_d     = 1'b0;
        cfg_err_d  = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start_i) begin
                    if (cfg_ok) begin
                        period_d   = cfg_period_i;
                        high_d     = cfg_high_i;
                        mode_d     = cfg_mode_i;
                        npulse_d   = cfg_npulse_i;
                        align_en_d = cfg_align_en_i;
                        ph_d       = '0;
                        pcnt_d     = '0;
                        stop_d     = 1'b0;
                        state_d    = cfg_align_en_i ? StArm : StRun;
                    end else begin
                        cfg_err_d = 1'b1;
                    end
                end
            end
            StArm: begin
                // Stop beats a coincident align edge so no pulse escapes.
                if (stop_i) begin
                    state_d = StIdle;
                    done_d  = 1'b1;
                end else if (align_en_q && align_rise) begin
                    state_d = StRun;
                    ph_d    = '0;
                end
            end
            StRun: begin
                if (ph_last) begin
                    ph_d   = '0;
                    pcnt_d = pcnt_inc;
                    if (stop_q || stop_i || (mode_q && (pcnt_inc == npulse_q))) begin
                        state_d = StIdle;
                        stop_d  = 1'b0;
                        done_d  = 1'b1;
                    end
                end else begin
                    ph_d = ph_q + PERIOD_W'(1);
                    if (stop_i) begin
                        stop_d = 1'b1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        // Output is decided from next-state values so sysref_o comes straight off a flop.
        sysref_d = (state_d == StRun) && (ph_d < high_d);
    end

    always_ff @(posedge pl_refclk_i) begin
        if (pl_rst_i) begin
            state_q      <= StIdle;
            ph_q         <= '0;
            pcnt_q       <= '0;
            period_q     <= '0;
            high_q       <= '0;
            mode_q       <= 1'b0;
            npulse_q     <= '0;
            align_en_q   <= 1'b0;
            stop_q       <= 1'b0;
            done_q       <= 1'b0;
            cfg_err_q    <= 1'b0;
            sysref_q     <= 1'b0;
            align_q      <= 1'b0;
            align_prev_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            ph_q         <= ph_d;
            pcnt_q       <= pcnt_d;
            period_q     <= period_d;
            high_q       <= high_d;
            mode_q       <= mode_d;
            npulse_q     <= npulse_d;
            align_en_q   <= align_en_d;
            stop_q       <= stop_d;
            done_q       <= done_d;
            cfg_err_q    <= cfg_err_d;
            sysref_q     <= sysref_d;
            align_q      <= align_i;
            align_prev_q <= align_q;
        end
    end

    assign sysref_o  = sysref_q;
    assign busy_o    = (state_q != StIdle);
    assign done_o    = done_q;
    assign cfg_err_o = cfg_err_q;

endmodule
